// File: rtl/sum_row_ctrl.sv
// Row scheduler for the pipelined sum tree: issues N-element chunks of a row, then
// accumulates the tree's partial sums into one saturating row total behind valid/ready.
module sum_row_ctrl #(
    parameter int unsigned N             = 32,
    parameter int unsigned OUT_BIT_WIDTH = 32,
    parameter int unsigned MAX_CHUNKS    = 8,
    parameter int unsigned TREE_LAT      = 5,
    parameter int unsigned CW            = $clog2(MAX_CHUNKS + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [CW-1:0]                 i_num_chunks,
    output logic                          o_busy,
    input  logic                          i_chunk_valid,
    output logic                          o_chunk_ready,
    output logic [$clog2(MAX_CHUNKS)-1:0] o_chunk_idx,
    output logic                          o_tree_valid,
    input  logic [OUT_BIT_WIDTH-1:0]      i_tree_sum,
    input  logic                          i_tree_valid,
    output logic [OUT_BIT_WIDTH-1:0]      o_row_sum,
    output logic                          o_row_valid,
    input  logic                          i_row_ready,
    output logic                          o_sat
);

    localparam int unsigned W  = OUT_BIT_WIDTH;
    localparam int unsigned IW = $clog2(MAX_CHUNKS);

    if (N == 0 || TREE_LAT == 0 || MAX_CHUNKS == 0) begin : g_param_check
        $error("sum_row_ctrl: N, TREE_LAT and MAX_CHUNKS must be non-zero");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e          state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   issued;
    logic [CW-1:0]   rcvd;
    logic [W-1:0]    acc;
    logic            sat;
    logic            busy;
    logic            ready;
    logic            row_valid;
    logic [IW-1:0]   idx;

    logic            accept;
    logic            take;
    logic [CW-1:0]   start_cnt;
    logic [CW-1:0]   issued_nxt;
    logic [CW-1:0]   rcvd_nxt;
    logic [W:0]      sum_ext;

    assign accept     = i_chunk_valid & ready;
    assign take       = i_tree_valid && (state == StIssue || state == StDrain) && (rcvd < count);
    assign start_cnt  = (i_num_chunks > CW'(MAX_CHUNKS)) ? CW'(MAX_CHUNKS) : i_num_chunks;
    assign issued_nxt = issued + CW'(accept);
    assign rcvd_nxt   = rcvd + CW'(take);
    assign sum_ext    = {1'b0, acc} + {1'b0, i_tree_sum};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= StIdle;
            count     <= '0;
            issued    <= '0;
            rcvd      <= '0;
            acc       <= '0;
            sat       <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            row_valid <= 1'b0;
            idx       <= '0;
        end else begin
            // Results can land while chunks are still being issued.
            if (take) begin
                rcvd <= rcvd_nxt;
                if (sum_ext[W] || (&acc)) begin
                    acc <= '1;
                    sat <= 1'b1;
                end else begin
                    acc <= sum_ext[W-1:0];
                end
            end

            case (state)
                StIdle: begin
                    if (i_start) begin
                        count  <= start_cnt;
                        issued <= '0;
                        rcvd   <= '0;
                        acc    <= '0;
                        sat    <= 1'b0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        if (start_cnt == '0) begin
                            state     <= StDone;
                            row_valid <= 1'b1;
                        end else begin
                            state <= StIssue;
                            ready <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    issued <= issued_nxt;
                    idx    <= IW'(issued_nxt);
                    if (issued_nxt == count) begin
                        state <= StDrain;
                        ready <= 1'b0;
                    end
                end
                StDrain: begin
                    if (rcvd_nxt == count) begin
                        state     <= StDone;
                        row_valid <= 1'b1;
                        idx       <= '0;
                    end
                end
                StDone: begin
                    if (i_row_ready) begin
                        state     <= StIdle;
                        row_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign o_busy        = busy;
    assign o_chunk_ready = ready;
    assign o_chunk_idx   = idx;
    assign o_tree_valid  = accept;
    assign o_row_sum     = acc;
    assign o_row_valid   = row_valid;
    assign o_sat         = sat;

endmodule

// File: doc/sum_row_ctrl.md
# sum_row_ctrl

Row scheduler for the 32-wide pipelined sum tree (`sumFinder32`) in the softmax normalisation path. It splits a row of up to `MAX_CHUNKS`×`N` exp values into `N`-element chunks and issues them to the tree. It tracks the tree's fixed latency and accumulates the partial sums into one saturating Q6.26 row total. It then holds that total on a valid/ready output until the consumer (reciprocal/divide stage) takes it.

## Interface
- `N`, 32, elements per chunk; equals tree width.
- `OUT_BIT_WIDTH`, 32, width of tree partial sums and of the row sum (Q6.26, unsigned).
- `MAX_CHUNKS`, 8, maximum chunks per row.
- `TREE_LAT`, 5, cycles from tree input valid to tree output valid.
- `CW`, `$clog2(MAX_CHUNKS+1)`, chunk-count width (derived).

Ports:
- `i_clk`  in  1  clock. Reset is synchronous and active-high.
- `i_rst`  in  1  synchronous active-high reset; shared with the sum tree.
- `i_start`  in  1  start-of-row pulse; sampled only in IDLE.
- `i_num_chunks`  in  CW  chunks in this row; sampled with `i_start`.
- `o_busy`  out  1  high in every state except IDLE.
- `i_chunk_valid`  in  1  upstream has chunk `o_chunk_idx` on the tree data bus.
- `o_chunk_ready`  out  1  high in ISSUE only.
- `o_chunk_idx`  out  `$clog2(MAX_CHUNKS)`  index of the next chunk to present.
- `o_tree_valid`  out  1  drives the tree `i_valid`; equals `i_chunk_valid & o_chunk_ready` (combinational).
- `i_tree_sum`  in  OUT_BIT_WIDTH  tree `o_sum`.
- `i_tree_valid`  in  1  tree `o_valid`.
- `o_row_sum`  out  OUT_BIT_WIDTH  accumulated row total.
- `o_row_valid`  out  1  row total is valid; held until accepted.
- `i_row_ready`  in  1  consumer accepts the total.
- `o_sat`  out  1  row total saturated; valid together with `o_row_valid`.

## Operation
- **States:**
  - IDLE: `i_start` → load count, clear accumulator, issued and received counters, and `o_sat`. Then go to ISSUE, or to DONE if the loaded count is 0.
  - ISSUE: each cycle with `i_chunk_valid & o_chunk_ready` is one accepted chunk; issued counter increments. When the issued count reaches the loaded count, go to DRAIN.
  - DRAIN: wait until the received count equals the loaded count, then go to DONE.
  - DONE: `o_row_valid` high. When `i_row_ready` is high, go to IDLE.
- **Count clamping:** `i_num_chunks` > `MAX_CHUNKS` is clamped to `MAX_CHUNKS`.
- **Start while busy:** `i_start` is ignored while `o_busy` is high.
- **Chunk index:** `o_chunk_idx` equals the issued count; it is 0 in IDLE and DONE.
- **Accumulation:**
  - Active in ISSUE and DRAIN. Each `i_tree_valid` with received count < loaded count adds `i_tree_sum` to the accumulator and increments the received count.
  - Results may arrive while still in ISSUE.
  - `i_tree_valid` arriving in IDLE, in DONE, or after the received count is complete is ignored.
- **Width and saturation:**
  - The add is performed at OUT_BIT_WIDTH+1 bits.
  - On carry-out, or if the accumulator is already all-ones, the accumulator becomes all-ones and `o_sat` is set (sticky for the row).
- **Output:** `o_row_sum` is the accumulator register. It keeps its value in IDLE until the next `i_start` clears it.
- **Zero-length row:** count 0 → DONE with `o_row_sum`=0 and `o_sat`=0.

## Timing
- **Reset values:** on `i_rst`, state=IDLE and all counters and the accumulator are 0. All outputs are 0: `o_busy`, `o_chunk_ready`, `o_chunk_idx`, `o_tree_valid`, `o_row_sum`, `o_row_valid`, `o_sat`.
- **Reset mid-row:** returns to IDLE next cycle. The tree is reset by the same signal, so no stale results are in flight.
- **Start:** `i_start` sampled at edge 0. ISSUE is active (`o_chunk_ready`=1) from cycle 1.
- **Latency:** a chunk accepted in cycle t produces `i_tree_valid` in cycle t+`TREE_LAT`. That result is in the accumulator after that edge.
- **Output timing:** `o_row_valid` rises the cycle after the last result is accumulated.
  - For K chunks accepted back-to-back from cycle 1, the last result arrives in cycle K+5 and `o_row_valid` is high from cycle K+6.
  - For a zero-length row, `o_row_valid` is high from cycle 1.
- **Throughput:** one chunk per cycle. Upstream stalls (`i_chunk_valid`=0) insert bubbles; the controller never stalls the tree.
- **Output handshake:** `o_row_valid`, `o_row_sum` and `o_sat` are stable until the cycle in which `i_row_ready`=1. IDLE follows at the next edge.
- **Back-to-back rows:** a new `i_start` is accepted at the earliest in the first cycle of IDLE after the handshake. There is no overlap of rows.

## Test plan
- **Basic 4-chunk row:** `i_num_chunks`=4, chunks issued cycles 1–4, tree sums 0x0400_0000 each. Expect `o_row_valid` high at cycle 10, `o_row_sum`=0x1000_0000, `o_sat`=0.
- **Upstream stalls:** 3 chunks with `i_chunk_valid` low in cycles 2–3. Expect `o_tree_valid` only in the 3 accepted cycles, `o_chunk_idx` sequence 0,1,1,1,2, and correct total 5 cycles after the last accept, +1.
- **Saturation:** 2 chunks with sums 0xC000_0000 each. Expect `o_row_sum`=0xFFFF_FFFF and `o_sat`=1. A following row of 1 chunk with sum 0x10 gives `o_row_sum`=0x10 and `o_sat`=0.
- **Consumer backpressure:** `i_row_ready`=0 for 6 cycles. Expect `o_row_valid` and `o_row_sum` held stable, `i_start` ignored, and IDLE the cycle after `i_row_ready`=1.
- **Boundaries:**
  - `i_num_chunks`=0: `o_row_valid` at cycle 1 with sum 0.
  - `i_num_chunks`=15: clamped, exactly 8 chunks accepted.
  - Spurious `i_tree_valid` in IDLE: no change.
- **Reset mid-row:** `i_rst` pulsed in DRAIN. All outputs are 0 next cycle, and a fresh 1-chunk row then completes with `o_row_valid` at cycle 7.
